// File: rtl/ift_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ift_sram_pkg
// Brief    : Shared types and helpers for the taint-tracking SRAM adapter.
// Revision : 1.0
// ============================================================================
package ift_sram_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned WidthBytes = DataWidth / 8;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [DataWidth-1:0] rdata_taint;
    logic                 tag_taint;
  } resp_entry_t;

  function automatic logic [DataWidth-1:0] expand_be(input logic [WidthBytes-1:0] be);
    logic [DataWidth-1:0] mask;
    for (int i = 0; i < DataWidth; i++) begin
      mask[i] = be[i/8];
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ift_sram_resp_buf.sv
`default_nettype none
// ============================================================================
// Module   : ift_sram_resp_buf
// Brief    : In-order response buffer (depth 1 or 2) with taint-aware full flag.
// Revision : 1.0
// ============================================================================
module ift_sram_resp_buf
  import ift_sram_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  resp_entry_t entry_i,
  input  logic        ready_taint_i,
  output resp_entry_t head_o,
  output logic        valid_o,
  output logic        full_taint_o,
  output logic [1:0]  count_o
);

  logic w_full;

  if (Depth == 1) begin : g_depth1
    resp_entry_t r_entry;
    logic        r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_entry <= '0;
        r_valid <= 1'b0;
      end else begin
        if (push_i) r_entry <= entry_i;
        r_valid <= push_i | (r_valid & ~pop_i);
      end
    end

    assign head_o  = r_entry;
    assign valid_o = r_valid;
    assign w_full  = r_valid;
    assign count_o = {1'b0, r_valid};
  end else begin : g_depth2
    resp_entry_t r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wptr   <= 1'b0;
        r_rptr   <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (push_i) begin
          r_mem[r_wptr] <= entry_i;
          r_wptr        <= ~r_wptr;
        end
        if (pop_i) r_rptr <= ~r_rptr;
        case ({push_i, pop_i})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end

    assign head_o  = r_mem[r_rptr];
    assign valid_o = (r_count != 2'd0);
    assign w_full  = (r_count == 2'd2);
    assign count_o = r_count;
  end

  // Readiness only depends on the consumer's ready while nothing can be freed otherwise.
  assign full_taint_o = w_full & ready_taint_i;

endmodule
`default_nettype wire

// File: rtl/ift_sram_req_adapter.sv
`default_nettype none
// ============================================================================
// Module   : ift_sram_req_adapter
// Brief    : Taint-tracking valid/ready to single-cycle SRAM request adapter.
//            IFT_SRAM_ADAPTER_OUTSTANDING2_EN selects a 2-deep response path.
// Revision : 1.0
// ============================================================================
module ift_sram_req_adapter
  import ift_sram_pkg::*;
#(
  parameter int unsigned Width     = 32,
  parameter int unsigned Depth     = 1 << 15,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumTaints = 1,
  localparam int unsigned Aw       = $clog2(Depth)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_valid_i,
  input  logic [NumTaints-1:0]                req_valid_i_taint,
  output logic                                req_ready_o,
  output logic [NumTaints-1:0]                req_ready_o_taint,
  input  logic                                req_we_i,
  input  logic [NumTaints-1:0]                req_we_i_taint,
  input  logic [AddrWidth-1:0]                req_addr_i,
  input  logic [NumTaints-1:0][AddrWidth-1:0] req_addr_i_taint,
  input  logic [Width-1:0]                    req_wdata_i,
  input  logic [NumTaints-1:0][Width-1:0]     req_wdata_i_taint,
  input  logic [Width/8-1:0]                  req_be_i,
  input  logic [NumTaints-1:0][Width/8-1:0]   req_be_i_taint,
  output logic                                resp_valid_o,
  output logic [NumTaints-1:0]                resp_valid_o_taint,
  input  logic                                resp_ready_i,
  input  logic [NumTaints-1:0]                resp_ready_i_taint,
  output logic [Width-1:0]                    resp_rdata_o,
  output logic [NumTaints-1:0][Width-1:0]     resp_rdata_o_taint,
  output logic                                sram_req_o,
  output logic [NumTaints-1:0]                sram_req_o_taint,
  output logic                                sram_write_o,
  output logic [NumTaints-1:0]                sram_write_o_taint,
  output logic [Aw-1:0]                       sram_addr_o,
  output logic [NumTaints-1:0][Aw-1:0]        sram_addr_o_taint,
  output logic [Width-1:0]                    sram_wdata_o,
  output logic [NumTaints-1:0][Width-1:0]     sram_wdata_o_taint,
  output logic [Width-1:0]                    sram_wmask_o,
  output logic [NumTaints-1:0][Width-1:0]     sram_wmask_o_taint,
  input  logic [Width-1:0]                    sram_rdata_i,
  input  logic [NumTaints-1:0][Width-1:0]     sram_rdata_i_taint
);

  localparam int unsigned B = $clog2(Width / 8);
`ifdef IFT_SRAM_ADAPTER_OUTSTANDING2_EN
  localparam int unsigned Cap = 2;
`else
  localparam int unsigned Cap = 1;
`endif
  localparam logic [1:0] CapL = 2'(Cap);

  if (NumTaints != 1 || Width != DataWidth || (Width % 8) != 0 || AddrWidth < Aw + B)
  begin : g_cfg_check
    $error("ift_sram_req_adapter: unsupported parameter combination");
  end

  logic        r_inflight;
  logic        r_inflight_we;
  logic        r_inflight_tag;
  logic        w_pop;
  logic        w_buf_valid;
  logic        w_full_taint;
  logic [1:0]  w_buf_count;
  logic [1:0]  w_used;
  resp_entry_t w_push_entry;
  resp_entry_t w_head;
  logic        w_unused_addr;

  // Free slots > 0 reduces to: something unclaimed, or the head leaves this cycle.
  assign w_pop       = resp_valid_o & resp_ready_i;
  assign w_used      = w_buf_count + {1'b0, r_inflight};
  assign req_ready_o = (w_used < CapL) | w_pop;

  assign sram_req_o   = req_valid_i & req_ready_o;
  assign sram_write_o = req_we_i;
  assign sram_addr_o  = req_addr_i[Aw+B-1:B];
  assign sram_wdata_o = req_wdata_i;
  assign sram_wmask_o = expand_be(req_be_i);

  for (genvar t = 0; t < NumTaints; t++) begin : g_taint
    assign sram_req_o_taint[t]   = req_valid_i_taint[t] | (req_valid_i & resp_ready_i_taint[t]);
    assign sram_write_o_taint[t] = req_we_i_taint[t];
    assign sram_addr_o_taint[t]  = req_addr_i_taint[t][Aw+B-1:B];
    assign sram_wdata_o_taint[t] = req_wdata_i_taint[t];
    assign sram_wmask_o_taint[t] = expand_be(req_be_i_taint[t]);
  end

  assign w_unused_addr = ^{req_addr_i[AddrWidth-1:Aw+B], req_addr_i[B-1:0],
                           req_addr_i_taint[0][AddrWidth-1:Aw+B], req_addr_i_taint[0][B-1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight     <= 1'b0;
      r_inflight_we  <= 1'b0;
      r_inflight_tag <= 1'b0;
    end else begin
      r_inflight <= sram_req_o;
      if (sram_req_o) begin
        r_inflight_we  <= req_we_i;
        r_inflight_tag <= sram_req_o_taint[0];
      end
    end
  end

  // Write responses carry neither data nor data taint; only the handshake tag.
  always_comb begin
    w_push_entry           = '0;
    w_push_entry.tag_taint = r_inflight_tag;
    if (!r_inflight_we) begin
      w_push_entry.rdata       = sram_rdata_i;
      w_push_entry.rdata_taint = sram_rdata_i_taint[0] | {Width{r_inflight_tag}};
    end
  end

  ift_sram_resp_buf #(
    .Depth (Cap)
  ) u_resp_buf (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (r_inflight),
    .pop_i         (w_pop),
    .entry_i       (w_push_entry),
    .ready_taint_i (resp_ready_i_taint[0]),
    .head_o        (w_head),
    .valid_o       (w_buf_valid),
    .full_taint_o  (w_full_taint),
    .count_o       (w_buf_count)
  );

  assign resp_valid_o          = w_buf_valid;
  assign resp_valid_o_taint[0] = w_buf_valid & w_head.tag_taint;
  assign resp_rdata_o          = w_head.rdata;
  assign resp_rdata_o_taint[0] = w_head.rdata_taint;
  assign req_ready_o_taint[0]  = w_full_taint;

endmodule
`default_nettype wire
